challenge_seq_ctrl: RTL
=======================

CHALLENGE_SEQ_CTRL -- requirements
Module: challenge_seq_ctrl

Interface
REQ-001 SHALL have parameter LE, default 128: challenge length, i.e. shift-register width driven by this block.
REQ-002 SHALL have parameter SETTLE, default 16: PUF evaluation/settle cycles per challenge (>=1).
REQ-003 SHALL have parameter RESP_W, default 8: response bits gathered per random word (>=1).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset: asynchronous assert, active-low.
REQ-006 SHALL have port start  in  1  request one random word; sampled only in IDLE.
REQ-007 SHALL have port lfsr_bit  in  1  next challenge bit from the seed LFSR.
REQ-008 SHALL have port lfsr_step  out  1  advance LFSR this cycle.
REQ-009 SHALL have port sr_en  out  1  shift enable to challenge shift register.
REQ-010 SHALL have port sr_din  out  1  serial data to challenge shift register.
REQ-011 SHALL have port puf_eval  out  1  PUF evaluate/enable.
REQ-012 SHALL have port puf_out  in  1  PUF response bit, valid by the SAMPLE cycle.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port rnd  out  RESP_W  last completed random word.
REQ-015 SHALL have port rnd_valid  out  1  one-cycle pulse when rnd updates.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, SETTLE, SAMPLE, DONE.
REQ-017 IDLE: start=1 -> SHIFT, clear shift counter, bit counter and accumulator; start=0 -> stay.
REQ-018 SHIFT: sr_en=1, lfsr_step=1, sr_din=lfsr_bit for exactly LE cycles, then -> SETTLE.
REQ-019 SETTLE: puf_eval=1 for exactly SETTLE cycles, then -> SAMPLE.
REQ-020 SAMPLE (1 cycle): puf_eval=1; accumulator <= {acc[RESP_W-2:0], puf_out}; bit counter +1; -> SHIFT if fewer than RESP_W bits taken, else -> DONE.
REQ-021 DONE (1 cycle): rnd <= accumulator, rnd_valid=1, -> IDLE.
REQ-022 Outside SHIFT: sr_en=0, lfsr_step=0, sr_din=0; outside SETTLE/SAMPLE: puf_eval=0.
REQ-023 Start-to-rnd_valid latency SHALL be exactly RESP_W*(LE+SETTLE+1)+1 cycles (start-sampled edge to DONE cycle).
REQ-024 start while busy, including in DONE, SHALL be ignored (no queuing); start held high SHALL launch a new word in the cycle after DONE.
REQ-025 rnd SHALL hold its value between DONE cycles; partial accumulations SHALL never reach rnd.
REQ-026 Counters SHALL be $clog2-sized (min 1 bit) and compare against LE-1 / SETTLE-1 / RESP_W-1; no wrap beyond terminal count.
REQ-027 All outputs SHALL be registered or decoded only from state; no combinational path from start or puf_out to any output.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, counters 0, accumulator 0, rnd=0, rnd_valid=0, busy=0, sr_en=0, lfsr_step=0, sr_din=0, puf_eval=0.
REQ-029 Reset mid-operation SHALL discard the partial word; first start after deassertion begins a fresh word.

Structure
REQ-030 State encoding enum and default LE/SETTLE/RESP_W constants SHALL live in shared package rng_pkg.
REQ-031 One sub-module SHALL be natural: seq_counter (parameterised terminal-count down/up counter), instantiated for shift and settle counts; FSM, bit counter and accumulator stay in challenge_seq_ctrl.

Verification (LE=4, SETTLE=2, RESP_W=4)
REQ-032 Reset: rst_n low mid-SHIFT -> all outputs 0 same cycle, state IDLE; start after release -> full 29-cycle word.
REQ-033 Nominal: single-cycle start, puf_out pattern 1,0,1,1 at SAMPLE cycles -> rnd=4'b1011, rnd_valid pulse exactly 29 cycles after start edge.
REQ-034 Shift framing: per bit, sr_en/lfsr_step high exactly 4 cycles, sr_din mirrors lfsr_bit; puf_eval high exactly 3 cycles (SETTLE+SAMPLE).
REQ-035 Busy start: start pulses during SHIFT, SETTLE and DONE -> no extra word, single rnd_valid.
REQ-036 Back-to-back: start held high -> rnd_valid pulses 30 cycles apart; rnd stable between pulses.
REQ-037 Glitch-free: puf_out toggling outside SAMPLE -> rnd unaffected.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared state encoding, default sizing and counter-width helper for the
// challenge sequencer.
package rng_pkg;

  localparam int unsigned DefLe    = 128;
  localparam int unsigned DefSettle = 16;
  localparam int unsigned DefRespW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StSettle,
    StSample,
    StDone
  } state_e;

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Terminal-count up counter: counts 0..Count-1 while enabled, flags the last
// value and returns to zero on the following enabled cycle.
module seq_counter
  import rng_pkg::*;
#(
  parameter int unsigned Count = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned Width = cnt_width(Count);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == Width'(Count - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/challenge_seq_ctrl.sv
// Sequences challenge shifting, PUF settle and response sampling to build one
// RESP_W-bit random word per start request.
module challenge_seq_ctrl
  import rng_pkg::*;
#(
  parameter int unsigned LE     = DefLe,
  parameter int unsigned SETTLE = DefSettle,
  parameter int unsigned RESP_W = DefRespW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              lfsr_bit,
  output logic              lfsr_step,
  output logic              sr_en,
  output logic              sr_din,
  output logic              puf_eval,
  input  logic              puf_out,
  output logic              busy,
  output logic [RESP_W-1:0] rnd,
  output logic              rnd_valid
);

  localparam int unsigned BitW = cnt_width(RESP_W);

  state_e            state_q, state_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [RESP_W-1:0] acc_q, acc_d;
  logic [RESP_W-1:0] rnd_q, rnd_d;
  logic [RESP_W-1:0] acc_shift;
  logic              shift_tc, settle_tc, bit_last;

  seq_counter #(
    .Count(LE)
  ) u_shift_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == StIdle),
    .en   (state_q == StShift),
    .tc   (shift_tc)
  );

  seq_counter #(
    .Count(SETTLE)
  ) u_settle_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == StIdle),
    .en   (state_q == StSettle),
    .tc   (settle_tc)
  );

  // Truncating cast keeps the low RESP_W bits, so RESP_W=1 needs no special case.
  assign acc_shift = RESP_W'({acc_q, puf_out});
  assign bit_last  = (bit_q == BitW'(RESP_W - 1));
  assign rnd       = rnd_q;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    acc_d     = acc_q;
    rnd_d     = rnd_q;
    sr_en     = 1'b0;
    lfsr_step = 1'b0;
    sr_din    = 1'b0;
    puf_eval  = 1'b0;
    rnd_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          bit_d   = '0;
          acc_d   = '0;
        end
      end
      StShift: begin
        sr_en     = 1'b1;
        lfsr_step = 1'b1;
        sr_din    = lfsr_bit;
        if (shift_tc) state_d = StSettle;
      end
      StSettle: begin
        puf_eval = 1'b1;
        if (settle_tc) state_d = StSample;
      end
      StSample: begin
        puf_eval = 1'b1;
        acc_d    = acc_shift;
        // rnd is loaded here so it is already valid during the DONE pulse.
        if (bit_last) begin
          rnd_d   = acc_shift;
          state_d = StDone;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = StShift;
        end
      end
      StDone: begin
        rnd_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bit_q   <= '0;
      acc_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule
